// File: rtl/word_packer_flex.sv
// ---------------------------------------------------------------------------
// word_packer_flex
// Reads bytes from a byte FIFO with a registered read-data interface. Packs
// them into WORD_WIDTH words and writes each word into a word FIFO. A flush
// request emits a partial word early, and so does an optional idle timeout.
// Every word goes out with a count of its valid bytes. Unused slots are zero.
//
// Optional feature macro: PACKER_TIMEOUT_EN
//   defined   - an idle counter flushes a partial word after TIMEOUT_CYCLES
//               empty cycles.
//   undefined - no counter exists; partial words leave only via flush.
//
// Ports:
//   clk        single clock
//   rst        asynchronous active-high reset
//   in_data    byte FIFO read data, valid the cycle after in_ren
//   in_empty   byte FIFO empty
//   in_ren     byte FIFO read enable
//   out_full   word FIFO full
//   out_wen    word FIFO write enable
//   out_data   packed word
//   out_bytes  number of valid bytes in out_data
//   flush      single-cycle request to emit the current partial word
//   busy       high while a word is being assembled or emitted
// ---------------------------------------------------------------------------
module word_packer_flex #(
    parameter int DATA_WIDTH     = 8,
    parameter int WORD_WIDTH     = 256,
    parameter int MSB_FIRST      = 0,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic [DATA_WIDTH-1:0]                       in_data,
    input  logic                                        in_empty,
    output logic                                        in_ren,
    input  logic                                        out_full,
    output logic                                        out_wen,
    output logic [WORD_WIDTH-1:0]                       out_data,
    output logic [$clog2(WORD_WIDTH/DATA_WIDTH+1)-1:0]  out_bytes,
    input  logic                                        flush,
    output logic                                        busy
);

    localparam int BYTES = WORD_WIDTH / DATA_WIDTH;
    localparam int CW    = $clog2(BYTES + 1);
    localparam logic [CW-1:0] LAST_SLOT = CW'(BYTES - 1);

    // Elaboration-time parameter guards.
    if ((BYTES < 2) || (BYTES * DATA_WIDTH != WORD_WIDTH)) begin : g_bad_ratio
        $error("word_packer_flex: WORD_WIDTH must be an integer multiple >= 2 of DATA_WIDTH");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("word_packer_flex: TIMEOUT_CYCLES must be >= 2");
    end

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_CAP  = 2'd1,
        S_EMIT = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          count_q, count_d;
    logic [WORD_WIDTH-1:0]  word_q, word_d;
    logic                   flush_pend_q, flush_pend_d;
    logic                   busy_q, busy_d;
    logic [CW-1:0]          slot_s;
    logic                   timeout_hit_s;

`ifdef PACKER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] timer_q, timer_d;

    // Idle counter: runs only while a partial word waits on an empty FIFO.
    always_comb begin
        timer_d = timer_q;
        if ((state_q == S_REQ) && (count_q != '0) && in_empty && !timeout_hit_s) begin
            timer_d = timer_q + TW'(1);
        end else if ((state_q != S_REQ) || (count_q == '0)) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q;
        end
    end

    assign timeout_hit_s = (timer_q >= TW'(TIMEOUT_CYCLES));

    // Idle counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end
`else
    assign timeout_hit_s = 1'b0;
`endif

    // Slot that the next captured byte lands in, by the selected byte order.
    always_comb begin
        if (MSB_FIRST != 0) begin
            slot_s = LAST_SLOT - count_q;
        end else begin
            slot_s = count_q;
        end
    end

    // Next-state logic plus the FIFO handshakes, which must be combinational.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        word_d       = word_q;
        flush_pend_d = flush_pend_q;
        in_ren       = 1'b0;
        out_wen      = 1'b0;
        case (state_q)
            S_REQ: begin
                // A flush with nothing assembled is simply forgotten.
                if (count_q == '0) begin
                    flush_pend_d = 1'b0;
                end else begin
                    flush_pend_d = flush_pend_q | flush;
                end
                // Pending bytes are always read before a flush/timeout is honoured.
                if (!in_empty && !rst) begin
                    in_ren  = 1'b1;
                    state_d = S_CAP;
                end else if ((count_q != '0) && (flush_pend_q || timeout_hit_s)) begin
                    state_d = S_EMIT;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_CAP: begin
                for (int i = 0; i < BYTES; i++) begin
                    if (slot_s == CW'(i)) begin
                        word_d[i*DATA_WIDTH +: DATA_WIDTH] = in_data;
                    end else begin
                        word_d[i*DATA_WIDTH +: DATA_WIDTH] = word_q[i*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
                count_d      = count_q + CW'(1);
                flush_pend_d = flush_pend_q | flush;
                if (count_q == LAST_SLOT) begin
                    state_d = S_EMIT;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_EMIT: begin
                // A flush arriving here is dropped: the word is already leaving.
                if (!out_full && !rst) begin
                    out_wen      = 1'b1;
                    count_d      = '0;
                    word_d       = '0;
                    flush_pend_d = 1'b0;
                    state_d      = S_REQ;
                end else begin
                    state_d = S_EMIT;
                end
            end
            default: begin
                state_d      = S_REQ;
                count_d      = '0;
                word_d       = '0;
                flush_pend_d = 1'b0;
            end
        endcase
        busy_d = (count_d != '0) || (state_d == S_EMIT);
    end

    // State, word and flush-pending registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_REQ;
            count_q      <= '0;
            word_q       <= '0;
            flush_pend_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            word_q       <= word_d;
            flush_pend_q <= flush_pend_d;
            busy_q       <= busy_d;
        end
    end

    assign out_data  = word_q;
    assign out_bytes = count_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_word_packer_flex.sv
// ---------------------------------------------------------------------------
// tb_word_packer_flex
// Drives two packers (LSB-first and MSB-first, DW=8, WORD=32) from a shared
// byte-FIFO model. Every word written is compared against words built from the
// byte stream with plain shift arithmetic.
// ---------------------------------------------------------------------------
module tb_word_packer_flex;

    localparam int NB = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_empty, out_full, flush;
    logic        ren0, wen0, busy0, ren1, wen1, busy1;
    logic [31:0] data0, data1;
    logic [2:0]  nb0, nb1;

    always #5 clk = ~clk;

    word_packer_flex #(.DATA_WIDTH(8), .WORD_WIDTH(32), .MSB_FIRST(0), .TIMEOUT_CYCLES(16)) dut_lsb (
        .clk(clk), .rst(rst), .in_data(in_data), .in_empty(in_empty), .in_ren(ren0),
        .out_full(out_full), .out_wen(wen0), .out_data(data0), .out_bytes(nb0),
        .flush(flush), .busy(busy0));

    word_packer_flex #(.DATA_WIDTH(8), .WORD_WIDTH(32), .MSB_FIRST(1), .TIMEOUT_CYCLES(16)) dut_msb (
        .clk(clk), .rst(rst), .in_data(in_data), .in_empty(in_empty), .in_ren(ren1),
        .out_full(out_full), .out_wen(wen1), .out_data(data1), .out_bytes(nb1),
        .flush(flush), .busy(busy1));

    int          total = 0;
    int          bad = 0;
    int          nren = 0;
    int          base;
    logic        rand_full = 1'b0;
    logic [7:0]  fifo[$];
    logic [34:0] got0[$];
    logic [34:0] got1[$];
    logic [7:0]  bs[$];
    logic [7:0]  grp[$];
    int          n;
    int          nexp;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Reference packing: byte i goes to slot i (or BYTES-1-i when MSB first).
    function automatic logic [31:0] pack(input logic [7:0] b[$], input int msb);
        logic [31:0] w = 32'h0;
        for (int i = 0; i < b.size(); i++) begin
            if (msb != 0) w = w | (32'(b[i]) << (8 * (NB - 1 - i)));
            else          w = w | (32'(b[i]) << (8 * i));
        end
        return w;
    endfunction

    task automatic push_byte(input logic [7:0] b);
        fifo.push_back(b);
        in_empty = 1'b0;
    endtask

    // One clock: observe mid-cycle, then model the FIFO after the edge.
    task automatic tick();
        logic r;
        @(negedge clk);
        r = ren0;
        if (ren0) nren++;
        if (wen0) got0.push_back({nb0, data0});
        if (wen1) got1.push_back({nb1, data1});
        @(posedge clk);
        #1;
        if (r && fifo.size() > 0) in_data = fifo.pop_front();
        in_empty = (fifo.size() == 0);
        flush = 1'b0;
        if (rand_full) out_full = ($urandom_range(0, 2) == 0);
    endtask

    task automatic wait_writes(input int cnt, input int budget, input string tag);
        int k = 0;
        while (got0.size() < cnt && k < budget) begin
            tick();
            k++;
        end
        check_eq({tag, "_wait"}, 64'(got0.size() >= cnt), 64'(1));
    endtask

    task automatic expect_write(input string tag, input logic [7:0] b[$]);
        logic [34:0] e0, e1;
        check_eq({tag, "_present"}, 64'(got0.size() > 0 && got1.size() > 0), 64'(1));
        if (got0.size() > 0 && got1.size() > 0) begin
            e0 = got0.pop_front();
            e1 = got1.pop_front();
            check_eq({tag, "_lsb_data"}, 64'(e0[31:0]), 64'(pack(b, 0)));
            check_eq({tag, "_msb_data"}, 64'(e1[31:0]), 64'(pack(b, 1)));
            check_eq({tag, "_bytes"}, 64'(e0[34:32]), 64'(b.size()));
            check_eq({tag, "_msb_bytes"}, 64'(e1[34:32]), 64'(b.size()));
        end
    endtask

    initial begin
        rst = 1'b1; in_empty = 1'b0; out_full = 1'b0; flush = 1'b0; in_data = 8'h00;
        #12;
        // Reset state, with in_empty low to show in_ren is held off.
        check_eq("rst_ren", 64'({ren0, ren1}), 64'(0));
        check_eq("rst_wen", 64'({wen0, wen1}), 64'(0));
        check_eq("rst_data", 64'(data0 | data1), 64'(0));
        check_eq("rst_bytes", 64'(nb0), 64'(0));
        check_eq("rst_busy", 64'(busy0), 64'(0));
        in_empty = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;

        // Full word, both byte orders.
        base = nren;
        bs = '{8'h11, 8'h22, 8'h33, 8'h44};
        foreach (bs[i]) push_byte(bs[i]);
        wait_writes(1, 40, "word");
        repeat (5) tick();
        check_eq("word_single", 64'(got0.size()), 64'(1));
        check_eq("word_ren", 64'(nren - base), 64'(4));
        check_eq("word_lit_lsb", 64'(got0[0][31:0]), 64'(32'h44332211));
        check_eq("word_lit_msb", 64'(got1[0][31:0]), 64'(32'h11223344));
        expect_write("word", bs);
        check_eq("word_idle_busy", 64'(busy0), 64'(0));

        // Back-pressure: word held while out_full, extra byte not read.
        base = nren;
        out_full = 1'b1;
        bs = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        foreach (bs[i]) push_byte(bs[i]);
        push_byte(8'hE5);
        repeat (12) tick();
        check_eq("full_ren4", 64'(nren - base), 64'(4));
        repeat (10) tick();
        check_eq("full_no_ren", 64'(nren - base), 64'(4));
        check_eq("full_no_write", 64'(got0.size()), 64'(0));
        check_eq("full_stable", 64'(data0), 64'(pack(bs, 0)));
        check_eq("full_busy", 64'(busy0), 64'(1));
        out_full = 1'b0;
        tick();
        check_eq("full_one_write", 64'(got0.size()), 64'(1));
        expect_write("full", bs);
        repeat (6) tick();
        flush = 1'b1;
        tick();
        wait_writes(1, 20, "tail1");
        bs = '{8'hE5};
        expect_write("tail1", bs);

        // Partial word via flush, then flush on an empty packer.
        bs = '{8'hAA, 8'hBB};
        foreach (bs[i]) push_byte(bs[i]);
        repeat (8) tick();
        flush = 1'b1;
        tick();
        wait_writes(1, 20, "flush");
        expect_write("flush", bs);
        flush = 1'b1;
        repeat (20) tick();
        check_eq("flush_empty", 64'(got0.size()), 64'(0));

        // Flush coinciding with the final byte of a full word: one write only.
        bs = '{8'h5C, 8'h6D, 8'h7E, 8'h8F};
        foreach (bs[i]) push_byte(bs[i]);
        repeat (7) tick();
        flush = 1'b1;
        repeat (15) tick();
        check_eq("fullflush_single", 64'(got0.size()), 64'(1));
        expect_write("fullflush", bs);

        // Stranded single byte: timeout (if built in) or only flush clears it.
        bs = '{8'h5A};
        push_byte(8'h5A);
`ifdef PACKER_TIMEOUT_EN
        wait_writes(1, 60, "tmo");
        expect_write("tmo", bs);
`else
        repeat (1000) tick();
        check_eq("no_tmo", 64'(got0.size()), 64'(0));
        check_eq("no_tmo_busy", 64'(busy0), 64'(1));
        flush = 1'b1;
        tick();
        wait_writes(1, 20, "tmo_flush");
        expect_write("tmo_flush", bs);
`endif

        // Reset mid-word discards the partial word.
        push_byte(8'h11); push_byte(8'h22); push_byte(8'h33);
        repeat (8) tick();
        rst = 1'b1;
        #1;
        check_eq("mrst_outs", 64'({ren0, wen0, busy0, nb0}), 64'(0));
        check_eq("mrst_data", 64'(data0 | data1), 64'(0));
        repeat (2) tick();
        rst = 1'b0;
        bs = '{8'h01, 8'h02, 8'h03, 8'h04};
        foreach (bs[i]) push_byte(bs[i]);
        wait_writes(1, 40, "mrst");
        repeat (3) tick();
        check_eq("mrst_single", 64'(got0.size()), 64'(1));
        expect_write("mrst", bs);

        // Random byte bursts under random back-pressure, tail flushed.
        for (int it = 0; it < 12; it++) begin
            n = $urandom_range(1, 9);
            bs.delete();
            for (int k = 0; k < n; k++) bs.push_back(8'($urandom));
            foreach (bs[k]) push_byte(bs[k]);
            rand_full = 1'b1;
            wait_writes(n / NB, 400, "rnd");
            rand_full = 1'b0;
            out_full = 1'b0;
            repeat (10) tick();
            flush = 1'b1;
            tick();
            nexp = n / NB + ((n % NB) != 0 ? 1 : 0);
            wait_writes(nexp, 40, "rnd_tail");
            repeat (4) tick();
            check_eq("rnd_count", 64'(got0.size()), 64'(nexp));
            for (int g = 0; g < nexp; g++) begin
                grp.delete();
                for (int j = g * NB; j < n && j < (g + 1) * NB; j++) grp.push_back(bs[j]);
                expect_write("rnd", grp);
            end
            got0.delete();
            got1.delete();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/word_packer_flex.md
Name: word_packer_flex

Overview:
Parametrised successor to the byte-to-word packer in the UART receive path. Pulls bytes from the byte FIFO using the FIFO's read-enable/registered-data interface. Assembles them into WORD_WIDTH words in a selectable byte order and writes each word into the word FIFO. Also emits partial words on an explicit flush or an idle timeout, together with a valid-byte count, so short UART bursts are not stranded.

Parameters:
DATA_WIDTH, 8, byte width from the byte FIFO.
WORD_WIDTH, 256, output word width; must be an integer multiple of DATA_WIDTH with ratio >= 2.
MSB_FIRST, 0, byte order. 0: first byte lands in bits [DATA_WIDTH-1:0]. 1: first byte lands in the top slot.
TIMEOUT_CYCLES, 1024, idle cycles before a partial word is flushed. Used only when PACKER_TIMEOUT_EN is defined; must be >= 2.

Ports:
clk  input  1  single clock.
rst  input  1  asynchronous, active-high reset.
in_data  input  DATA_WIDTH  byte FIFO data_out; valid the cycle after in_ren.
in_empty  input  1  byte FIFO empty.
in_ren  output  1  byte FIFO read enable.
out_full  input  1  word FIFO full.
out_wen  output  1  word FIFO write enable.
out_data  output  WORD_WIDTH  packed word.
out_bytes  output  $clog2(BYTES+1)  number of valid bytes in out_data (BYTES = WORD_WIDTH/DATA_WIDTH).
flush  input  1  single-cycle request to emit the current partial word.
busy  output  1  high while count > 0 or state is S_EMIT.

Behaviour:
- Reset (asynchronous, active-high) clears: state=S_REQ, count=0, word register=0, flush_pend=0, timeout counter=0. Consequently in_ren=0, out_wen=0, out_data=0, out_bytes=0 and busy=0 while rst is high.
- FSM has three states: S_REQ, S_CAP, S_EMIT.
- S_REQ:
  - in_ren = !in_empty (combinational); if in_ren, go to S_CAP.
  - Else, if count>0 and (flush_pend or timeout hit), go to S_EMIT.
  - Priority rule: an available byte is read before any flush or timeout is honoured.
- S_CAP:
  - Write in_data into slot count: slot i is bits [i*DW +: DW] when MSB_FIRST=0, bits [(BYTES-1-i)*DW +: DW] when MSB_FIRST=1.
  - count <= count+1.
  - If count+1==BYTES, go to S_EMIT; else go to S_REQ.
  - Sustained rate is one byte per 2 cycles.
- S_EMIT:
  - out_wen = !out_full (combinational); out_data and out_bytes (=count) are held stable.
  - While out_full=1: no write and no in_ren.
  - On write: count<=0, word register<=0, flush_pend<=0, go to S_REQ.
- Unused slots in a partial word are zero.
- flush is sampled in any state into flush_pend.
  - flush_pend clears if count==0 in S_REQ; a flush on an empty packer produces no write.
  - flush arriving during S_CAP is honoured after that byte is captured.
  - flush arriving in S_EMIT is dropped, since the word is already being emitted.
- Full word plus flush in the same cycle: exactly one write, out_bytes=BYTES.
- Reset mid-word discards the partial word with no write; the next bytes start a fresh word at slot 0.

Optional Feature:
PACKER_TIMEOUT_EN.
- Defined: an idle counter increments each S_REQ cycle with count>0 and in_empty=1, and resets on every byte capture or emit. Reaching TIMEOUT_CYCLES asserts "timeout hit", causing S_REQ→S_EMIT with the partial word.
- Undefined: no counter logic exists; partial words leave only via flush.

Test Plan:
All scenarios use DW=8, WORD_WIDTH=32.
1. Bytes 11,22,33,44 with MSB_FIRST=0 → single out_wen pulse, out_data=0x44332211, out_bytes=4, 4 in_ren pulses.
2. Same bytes with MSB_FIRST=1 → out_data=0x11223344, out_bytes=4.
3. Full word with out_full=1 for 10 cycles → out_wen=0, no in_ren, out_data stable. Drop out_full → exactly one write next cycle.
4. Bytes AA,BB then flush pulse → out_data=0x0000BBAA, out_bytes=2. Second flush with count=0 → no write.
5. PACKER_TIMEOUT_EN defined, TIMEOUT_CYCLES=16, one byte 5A then empty → write of 0x0000005A, out_bytes=1, 16 idle cycles after capture. Without the macro → no write after 1000 cycles.
6. rst asserted after 3 bytes (11,22,33) → all outputs 0 immediately. Then bytes 01,02,03,04 → 0x04030201 with no residue from 11,22,33.
